// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared master IDs, bus widths and request field struct
package mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    MST_CPU  = 2'd0,
    MST_DMA  = 2'd1,
    MST_NONE = 2'd2
  } mst_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [3:0]        wstrb;
  } req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one master's request/grant/read-response bundle
interface mem_arbiter_if;
  logic                                req;
  logic                                we;
  logic [mem_arbiter_pkg::ADDR_W-1:0]  addr;
  logic [mem_arbiter_pkg::XLEN-1:0]    wdata;
  logic [3:0]                          wstrb;
  logic                                gnt;
  logic                                rvalid;
  logic [mem_arbiter_pkg::XLEN-1:0]    rdata;
  modport master(output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_rd_owner_pipe.sv
// mem_arbiter_rd_owner_pipe: RD_LAT-deep shift register of read owner IDs
module mem_arbiter_rd_owner_pipe import mem_arbiter_pkg::*; #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic clr,
  input  mst_e in_id,
  output mst_e out_id
);
  mst_e pipe [RD_LAT];
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= MST_NONE;
    end else begin
      pipe[0] <= in_id;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign out_id = pipe[RD_LAT-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/DMA to unified RAM arbiter with starvation guard and read routing
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int CPU_PRIO     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [31:0]       conflict_cnt
);
  logic       r0, r1, g0, g1, at_limit;
  logic [7:0] starve_cnt;
  mst_e       last_grant, rd_in, rd_out;
  req_t       f0, f1, sel;
  // requests are masked during reset so every output reads 0 while rst_n is low
  assign r0 = rst_n & m0.req;
  assign r1 = rst_n & m1.req;
  assign f0 = {m0.we, m0.addr, m0.wdata, m0.wstrb};
  assign f1 = {m1.we, m1.addr, m1.wdata, m1.wstrb};
  assign at_limit = starve_cnt == 8'(STARVE_LIMIT);
  always_comb begin
    g1 = r1 & (!r0 | (CPU_PRIO != 0 ? at_limit : last_grant == MST_CPU));
    g0 = r0 & !g1;
    sel = g1 ? f1 : g0 ? f0 : '0;
    rd_in = ((g0 | g1) && !sel.we) ? (g1 ? MST_DMA : MST_CPU) : MST_NONE;
  end
  assign m0.gnt = g0;
  assign m1.gnt = g1;
  assign mem_req = g0 | g1;
  assign {mem_we, mem_addr, mem_wdata, mem_wstrb} = sel;
  mem_arbiter_rd_owner_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk   (clk),
    .clr   (!rst_n),
    .in_id (rd_in),
    .out_id(rd_out)
  );
  assign m0.rvalid = rst_n && rd_out == MST_CPU;
  assign m1.rvalid = rst_n && rd_out == MST_DMA;
  assign m0.rdata = m0.rvalid ? mem_rdata : '0;
  assign m1.rdata = m1.rvalid ? mem_rdata : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt   <= '0;
      last_grant   <= MST_CPU;
      conflict_cnt <= '0;
    end else begin
      starve_cnt <= (!r1 || g1) ? '0 : at_limit ? starve_cnt : starve_cnt + 8'd1;
      if (g0 | g1) last_grant <= g1 ? MST_DMA : MST_CPU;
      if (m0.req && m1.req) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant priority, read routing, copy traffic and reset
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  mem_arbiter_if ma0(), ma1(), mb0(), mb1();
  logic        mreq_a, mwe_a, mreq_b, mwe_b;
  logic [31:0] maddr_a, mwdata_a, mrdata_a, cc_a, maddr_b, mwdata_b, mrdata_b, cc_b;
  logic [3:0]  mwstrb_a, mwstrb_b;
  logic [31:0] ram_a [512];
  logic [31:0] ram_b [512];
  logic [31:0] rd_a, rb1, rb2;

  mem_arbiter dut_a (
    .clk(clk), .rst_n(rst_n), .m0(ma0), .m1(ma1),
    .mem_req(mreq_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
    .mem_wstrb(mwstrb_a), .mem_rdata(mrdata_a), .conflict_cnt(cc_a)
  );
  mem_arbiter #(.RD_LAT(2), .STARVE_LIMIT(4), .CPU_PRIO(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .m0(mb0), .m1(mb1),
    .mem_req(mreq_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
    .mem_wstrb(mwstrb_b), .mem_rdata(mrdata_b), .conflict_cnt(cc_b)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 512; k++) ram_a[k] <= (k >= 128 && k < 144) ? 32'hA000_0000 + 32'(k - 128) : '0;
    end else if (mreq_a) begin
      if (mwe_a) begin
        for (int j = 0; j < 4; j++) if (mwstrb_a[j]) ram_a[maddr_a[10:2]][8*j+:8] <= mwdata_a[8*j+:8];
      end else rd_a <= ram_a[maddr_a[10:2]];
    end
  end
  assign mrdata_a = rd_a;

  always @(posedge clk) begin
    rb2 <= rb1;
    if (!rst_n) begin
      for (int k = 0; k < 512; k++) ram_b[k] <= (k >= 128 && k < 144) ? 32'hA000_0000 + 32'(k - 128) : '0;
    end else if (mreq_b) begin
      if (mwe_b) begin
        for (int j = 0; j < 4; j++) if (mwstrb_b[j]) ram_b[maddr_b[10:2]][8*j+:8] <= mwdata_b[8*j+:8];
      end else rb1 <= ram_b[maddr_b[10:2]];
    end
  end
  assign mrdata_b = rb2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel_b, input logic sel_m1, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!sel_b && !sel_m1) begin ma0.req = req; ma0.we = we; ma0.addr = addr; ma0.wdata = wdata; ma0.wstrb = 4'hF; end
    if (!sel_b &&  sel_m1) begin ma1.req = req; ma1.we = we; ma1.addr = addr; ma1.wdata = wdata; ma1.wstrb = 4'hF; end
    if ( sel_b && !sel_m1) begin mb0.req = req; mb0.we = we; mb0.addr = addr; mb0.wdata = wdata; mb0.wstrb = 4'hF; end
    if ( sel_b &&  sel_m1) begin mb1.req = req; mb1.we = we; mb1.addr = addr; mb1.wdata = wdata; mb1.wstrb = 4'hF; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i, phase, cpu_cnt, cyc;
    logic [31:0] data;
    logic g0, g1;
    for (int k = 0; k < 4; k++) drive(k[1], k[0], 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("rst_m0_gnt", {31'd0, ma0.gnt}, 0);
    chk("rst_m1_gnt", {31'd0, ma1.gnt}, 0);
    chk("rst_mem_req", {31'd0, mreq_a}, 0);
    chk("rst_rvalid", {30'd0, ma0.rvalid, ma1.rvalid}, 0);
    chk("rst_conflict", cc_a, 0);
    rst_n = 1'b1;

    drive(0, 0, 1, 0, 32'h200, 0);
    #1;
    chk("rd_m0_gnt", {31'd0, ma0.gnt}, 1);
    chk("rd_m1_gnt", {31'd0, ma1.gnt}, 0);
    chk("rd_mem_addr", maddr_a, 32'h200);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rd_m0_rvalid", {31'd0, ma0.rvalid}, 1);
    chk("rd_m0_rdata", ma0.rdata, 32'hA000_0000);
    chk("rd_m1_rvalid", {31'd0, ma1.rvalid}, 0);
    chk("rd_m1_rdata", ma1.rdata, 0);
    chk("rd_mem_idle", {mreq_a, maddr_a[30:0]}, 0);
    tick();
    chk("rd_m0_rvalid_pulse", {31'd0, ma0.rvalid}, 0);

    drive(0, 0, 1, 0, 32'h200, 0);
    drive(0, 1, 1, 0, 32'h204, 0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("prio_g1_%0d", k), {31'd0, ma1.gnt}, (k % 5 == 4) ? 1 : 0);
      chk($sformatf("prio_g0_%0d", k), {31'd0, ma0.gnt}, (k % 5 == 4) ? 0 : 1);
      tick();
      if (k == 4) chk("conflict_5", cc_a, 5);
    end
    chk("conflict_10", cc_a, 10);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    tick();

    drive(1, 0, 1, 1, 32'h3F0, 32'h1);
    drive(1, 1, 1, 1, 32'h3F4, 32'h2);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("alt_g1_%0d", k), {31'd0, mb1.gnt}, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_g0_%0d", k), {31'd0, mb0.gnt}, (k % 2 == 0) ? 0 : 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    tick();
    tick();

    drive(1, 0, 1, 0, 32'h200, 0);
    #1;
    chk("lat2_c0_gnt", {31'd0, mb0.gnt}, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 32'h204, 0);
    #1;
    chk("lat2_c1_gnt", {31'd0, mb1.gnt}, 1);
    chk("lat2_c1_rvalid", {30'd0, mb0.rvalid, mb1.rvalid}, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 32'h208, 0);
    #1;
    chk("lat2_c2_gnt", {31'd0, mb0.gnt}, 1);
    chk("lat2_c2_rvalid", {30'd0, mb0.rvalid, mb1.rvalid}, 2'b10);
    chk("lat2_c2_rdata0", mb0.rdata, 32'hA000_0000);
    chk("lat2_c2_rdata1", mb1.rdata, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("lat2_c3_rvalid", {30'd0, mb0.rvalid, mb1.rvalid}, 2'b01);
    chk("lat2_c3_rdata1", mb1.rdata, 32'hA000_0001);
    chk("lat2_c3_rdata0", mb0.rdata, 0);
    tick();
    chk("lat2_c4_rvalid", {30'd0, mb0.rvalid, mb1.rvalid}, 2'b10);
    chk("lat2_c4_rdata0", mb0.rdata, 32'hA000_0002);
    tick();
    chk("lat2_c5_rvalid", {30'd0, mb0.rvalid, mb1.rvalid}, 0);

    i = 0; phase = 0; cpu_cnt = 0; cyc = 0; data = '0;
    while (i < 16 && cyc < 400) begin
      drive(0, 0, 1, 1, 32'h500, 32'(cpu_cnt));
      drive(0, 1, phase != 1, phase == 2, (phase == 2 ? 32'h300 : 32'h200) + 32'(4 * i), data);
      #1;
      if (phase == 1 && ma1.rvalid) begin
        data = ma1.rdata;
        phase = 2;
      end
      g0 = ma0.gnt;
      g1 = ma1.gnt;
      tick();
      cyc++;
      if (g0) begin
        chk($sformatf("copy_cpu_%0d", cpu_cnt), ram_a[320], 32'(cpu_cnt));
        cpu_cnt++;
      end
      if (g1 && phase == 0) phase = 1;
      else if (g1 && phase == 2) begin
        i++;
        phase = 0;
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    tick();
    chk("copy_done", 32'(i), 16);
    for (int k = 0; k < 16; k++) chk($sformatf("copy_dst_%0d", k), ram_a[192+k], 32'hA000_0000 + 32'(k));
    chk("copy_cpu_last", ram_a[320], 32'(cpu_cnt - 1));

    drive(0, 1, 1, 0, 32'h204, 0);
    #1;
    chk("rst_fl_gnt", {31'd0, ma1.gnt}, 1);
    tick();
    rst_n = 1'b0;
    drive(0, 1, 0, 0, 0, 0);
    #1;
    chk("rst_fl_rvalid_low", {30'd0, ma0.rvalid, ma1.rvalid}, 0);
    chk("rst_fl_rdata", ma1.rdata, 0);
    chk("rst_fl_mem", {mreq_a, mwe_a, maddr_a[29:0]}, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_fl_rvalid_after", {30'd0, ma0.rvalid, ma1.rvalid}, 0);
    chk("rst_fl_conflict", cc_a, 0);
    chk("rst_fl_gnt_after", {30'd0, ma0.gnt, ma1.gnt}, 0);
    tick();
    chk("rst_fl_rvalid_late", {30'd0, ma0.rvalid, ma1.rvalid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter between the CPU data port (m0) and the DMA engine's master port (m1), in front of the shared unified RAM.
- Issues one memory access per cycle.
- Routes read data back to the requester after the fixed RAM read latency.
- Uses CPU-favoured priority with a starvation guard, so DMA bursts make progress while the CPU keeps executing from RAM.

Parameters:
- RD_LAT, 1: RAM read latency in cycles (accept to data); legal range 1..4.
- STARVE_LIMIT, 4: consecutive cycles m1 may wait while m0 wins before m1 is forced a grant; legal range 1..255.
- CPU_PRIO, 1: 1 = m0 wins ties subject to the starvation guard; 0 = strict alternation on tie.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- m0_req  in  1  CPU access request; held until m0_gnt
- m0_we  in  1  write enable
- m0_addr  in  `ADDR_W  byte address
- m0_wdata  in  `XLEN  write data
- m0_wstrb  in  4  byte strobes
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  read data valid
- m0_rdata  out  `XLEN  read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata: same as m0, DMA side
- mem_req  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  `ADDR_W  RAM address
- mem_wdata  out  `XLEN  RAM write data
- mem_wstrb  out  4  RAM byte strobes
- mem_rdata  in  `XLEN  RAM read data, valid RD_LAT cycles after a read accept
- conflict_cnt  out  32  count of cycles with both requests asserted

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0.
  - last_grant = m0.
  - Starvation counter 0.
  - Read-owner pipeline cleared; in-flight read responses are dropped, so no rvalid follows reset.
  - conflict_cnt 0.
- Grant decision, combinational in the cycle of request:
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both, CPU_PRIO=1: grant m1 if starve_cnt == STARVE_LIMIT, else grant m0.
  - Both, CPU_PRIO=0: grant the master not equal to last_grant.
  - At most one gnt per cycle.
  - mem_req = m0_gnt | m1_gnt.
  - mem_* fields are muxed from the granted master and are 0 when idle.
- Zero-cycle grant: gnt is asserted in the same cycle as the req it accepts. A master deasserting req without gnt is legal; its request is withdrawn.
- starve_cnt (8 bit):
  - Increments when m1_req && !m1_gnt.
  - Resets to 0 on m1_gnt or when !m1_req.
  - Saturates at STARVE_LIMIT.
- last_grant updates on every grant.
- Read routing:
  - On a granted read (we=0), the owner ID is pushed into an RD_LAT-deep shift pipeline; writes push "none".
  - RD_LAT cycles later, the owner's rvalid pulses for 1 cycle and its rdata = mem_rdata.
  - The other master's rdata holds 0.
  - Back-to-back reads from alternating masters return in grant order, one per cycle.
- Writes produce no response; they are complete on gnt.
- conflict_cnt increments on every cycle with m0_req && m1_req and wraps at 2^32.
- Address ranges are not decoded here: both masters see the whole RAM, and MMIO is decoded upstream of m0.

Decomposition:
- Shared package/defines: master ID constants (MST_CPU=0, MST_DMA=1, MST_NONE) and the request field struct {we, addr, wdata, wstrb}, reused by the future peripheral crossbar.
- One sub-module, rd_owner_pipe: a parameterised RD_LAT shift register of owner IDs with a synchronous clear, instantiated once.

Test Plan:
- Only m0 reads 0x200 with RAM word 0xA0000000 → m0_gnt same cycle; 1 cycle later m0_rvalid=1, m0_rdata=0xA0000000; m1 signals stay 0.
- Both request continuously with CPU_PRIO=1, STARVE_LIMIT=4 → grant pattern m0,m0,m0,m0,m1 repeating; conflict_cnt=5 after 5 cycles.
- CPU_PRIO=0, both continuously → strict alternation m1,m0,m1,… (last_grant=m0 after reset); no master idle more than 1 cycle.
- DMA copies 16 words 0x200→0x300 while the CPU stores an incrementing counter to 0x500 → destination words 0xA0000000+i for i=0..15, and the counter strictly increases during the copy.
- Alternating reads m0@0x200, m1@0x204, m0@0x208 on consecutive cycles with RD_LAT=2 → rvalid pulses in the same order, with each rdata matching its own address.
- rst_n low for 1 cycle one cycle after a granted m1 read → no m1_rvalid afterwards; all outputs 0; conflict_cnt 0.
